cic_comp_fir: RTL

Compensation FIR that sits directly downstream of the CIC decimator. It consumes one decimated sample per input valid strobe and corrects the CIC passband droop. It uses a time-multiplexed direct-form FIR with a single multiplier, a circular sample buffer and runtime-writable coefficients. It outputs one rounded, saturated sample per accepted input, with a valid strobe.

---
 rtl/cic_comp_fir_if.sv | 28 ++
 rtl/cic_comp_fir.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cic_comp_fir_if.sv
// Sample/coefficient bus between the CIC decimator side and the compensation FIR.
// master drives samples and coefficients; slave is the filter.
interface cic_comp_fir_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16
);
  logic                         en_i;
  logic signed [DATA_WIDTH-1:0] data_i;
  logic                         val_i;
  logic                         coef_we_i;
  logic [5:0]                   coef_addr_i;
  logic signed [COEF_WIDTH-1:0] coef_data_i;
  logic signed [OUT_WIDTH-1:0]  data_o;
  logic                         val_o;
  logic                         busy_o;
  logic                         drop_o;

  modport master (
    output en_i, data_i, val_i, coef_we_i, coef_addr_i, coef_data_i,
    input  data_o, val_o, busy_o, drop_o
  );

  modport slave (
    input  en_i, data_i, val_i, coef_we_i, coef_addr_i, coef_data_i,
    output data_o, val_o, busy_o, drop_o
  );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC droop compensation FIR: time-multiplexed single-multiplier direct form,
// circular sample history, runtime-writable taps, rounded and saturated output.
module cic_comp_fir #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int NTAPS      = 21,
  parameter int SHIFT      = 15,
  parameter int ACC_WIDTH  = 37
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  cic_comp_fir_if.slave  bus
);
  localparam int IDX_W  = $clog2(NTAPS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NTAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

  state_t                       state, state_nxt;
  logic signed [DATA_WIDTH-1:0] samples [NTAPS];
  logic signed [COEF_WIDTH-1:0] coefs   [NTAPS];
  logic [IDX_W-1:0]             wptr, rptr, tap;
  logic                         flush_cnt;
  logic signed [PROD_W-1:0]     prod;
  logic                         prod_vld;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  rnd_sum, shifted;
  logic signed [OUT_WIDTH-1:0]  sat_val, data_q;
  logic                         drop_q;
  logic                         busy, accept;

  assign accept = bus.en_i & bus.val_i & ~busy;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      state <= IDLE;
    else if (bus.en_i) state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == LAST) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt) state_nxt = OUT;
      OUT:     state_nxt = accept ? MAC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == MAC) || (state == FLUSH);
    bus.busy_o = busy;
    bus.val_o  = (state == OUT);
  end

  // Round half toward +inf, arithmetic shift, then clamp to the output range.
  always_comb begin
    rnd_sum = acc + RND;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
    else                        sat_val = shifted[OUT_WIDTH-1:0];
  end

  // NOTE: the history and coefficient arrays are flops with an explicit reset,
  // because start-up output must see zero history and zero taps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        samples[i] <= '0;
        coefs[i]   <= '0;
      end
      wptr      <= '0;
      rptr      <= '0;
      tap       <= '0;
      flush_cnt <= 1'b0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      data_q    <= '0;
      drop_q    <= 1'b0;
    end else if (bus.en_i) begin
      if (bus.coef_we_i && (int'(bus.coef_addr_i) < NTAPS))
        coefs[bus.coef_addr_i[IDX_W-1:0]] <= bus.coef_data_i;

      if (bus.val_i && busy) drop_q <= 1'b1;

      if (accept) begin
        samples[wptr] <= bus.data_i;
        wptr          <= (wptr == LAST) ? '0 : wptr + 1'b1;
        rptr          <= wptr;
        tap           <= '0;
      end else if (state == MAC) begin
        prod <= PROD_W'(samples[rptr]) * PROD_W'(coefs[tap]);
        rptr <= (rptr == '0) ? LAST : rptr - 1'b1;
        if (tap != LAST) tap <= tap + 1'b1;
      end

      // Multiply and accumulate are separate registered stages; FLUSH drains them.
      prod_vld  <= (state == MAC);
      flush_cnt <= (state == FLUSH) && !flush_cnt;

      if (accept)        acc <= '0;
      else if (prod_vld) acc <= acc + ACC_WIDTH'(prod);

      if (state == FLUSH && flush_cnt) data_q <= sat_val;
    end
  end

  assign bus.data_o = data_q;
  assign bus.drop_o = drop_q;
endmodule
